kronos_imem_bridge: RTL and testbench
=====================================

Name: kronos_imem_bridge

Overview:
- Upstream neighbour of the instruction fetch stage. Sits between the core's instruction port (instr_addr/instr_req/instr_data/instr_ack) and a Wishbone B4 classic read-only master bus.
- Converts the fetch-stage contract ("ack in cycle N returns the word for the address presented in cycle N-1; on a miss the address is held") into single Wishbone read cycles.
- Holds a one-word result buffer so that stalls and repeated addresses never re-fetch.
- Adds bus-error and timeout handling.

Parameters:
- ERR_INSTR, 32'h0000_0000: instruction word returned on bus error or timeout. The default is an illegal instruction.
- TIMEOUT, 16: maximum cycles spent in BUS before the access is abandoned. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- instr_addr  in  32  fetch address from the core; bits [1:0] ignored
- instr_req  in  1  fetch request
- instr_data  out  32  fetched word (buf_data)
- instr_ack  out  1  instr_data valid for the address presented in the previous cycle
- instr_err  out  1  qualifies instr_ack; word came from an error or timeout
- wb_adr_o  out  32  bus address; bits [1:0] always 0
- wb_dat_i  in  32  bus read data
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe; always equal to wb_cyc_o
- wb_we_o  out  1  constant 0
- wb_sel_o  out  4  constant 4'hF
- wb_ack_i  in  1  bus ack
- wb_err_i  in  1  bus error

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Registered state:
  - addr_q[29:0] and req_q: instr_addr[31:2] and instr_req, sampled every cycle.
  - buf_vld, buf_addr[29:0], buf_data[31:0], buf_err: the result buffer.
  - state (IDLE, BUS), bus_addr[29:0], cnt[$clog2(TIMEOUT+1)-1:0].
- Reset values: state=IDLE; buf_vld=0; buf_data=0; buf_err=0; req_q=0; cnt=0.
  - While rst=1, wb_cyc_o/wb_stb_o=0 combinationally in that same cycle, and instr_ack=0.
- Response:
  - instr_ack = req_q & buf_vld & (buf_addr==addr_q).
  - instr_data=buf_data; instr_err=buf_err & instr_ack.
  - All three come purely from registers (no wb_* to instr_* combinational path).
- Hit/launch (IDLE): hit = buf_vld & (buf_addr==instr_addr[31:2]); launch = instr_req & ~hit & ~rst.
  - When launch=1: wb_cyc_o=wb_stb_o=1 and wb_adr_o={instr_addr[31:2],2'b00} combinationally, in the same cycle.
- IDLE transitions (when launch=1):
  - wb_err_i or wb_ack_i seen the same cycle: fill the buffer, stay IDLE.
  - Otherwise: bus_addr<=instr_addr[31:2], cnt<=0, go to BUS.
- BUS outputs: wb_cyc_o=wb_stb_o=1, wb_adr_o={bus_addr,2'b00}. These are held regardless of instr_addr changes.
  - A classic cycle is never aborted except by timeout.
- BUS transitions:
  - wb_err_i: buffer fill with error, go to IDLE.
  - Else wb_ack_i: buffer fill, go to IDLE.
  - Else TIMEOUT!=0 and cnt==TIMEOUT-1: error fill, drop cyc next cycle, go to IDLE.
  - Else cnt<=cnt+1.
- Buffer fill: buf_vld<=1 and buf_addr<=the accessed word address.
  - On ack: buf_data<=wb_dat_i, buf_err<=0.
  - On error or timeout: buf_data<=ERR_INSTR, buf_err<=1.
- Simultaneous wb_ack_i and wb_err_i: error wins.
- Latency:
  - Zero-wait slave (ack in the strobe cycle): instr_ack one cycle after the address is presented, giving one word per cycle at full throughput.
  - Slave acking k cycles after the strobe: instr_ack at cycle k+1.
- Address changed during BUS (e.g. a branch): the in-flight access completes and fills the buffer.
  - No instr_ack, because addr_q mismatches.
  - The new address launches on the first IDLE cycle.
- Stale buffer: a word is returned only while the address still matches. The buffer is never invalidated except by reset (instruction memory is treated as read-only).
- instr_req=0: no launch. instr_ack is 0 next cycle. A BUS access already started still completes.
- Reset mid-BUS: cyc/stb drop in the reset cycle; the buffer is invalidated. The slave must tolerate cyc deassertion (B4 rule).

Test Plan:
- Zero-wait slave, mem[0x0,0x4,0x8]=0x11,0x22,0x33, IF presents 0x0,0x4,0x8 on cycles 0,1,2 -> instr_ack=1 on cycles 1,2,3 with data 0x11,0x22,0x33; exactly 3 wb strobes.
- Slave acking 1 cycle after strobe, addr 0x100 (data 0xDEADBEEF) held -> cyc=1 cycles 0-1; instr_ack=0 cycle 1; instr_ack=1 cycle 2 with 0xDEADBEEF.
- Launch 0x20 with a 3-cycle slave; IF switches to 0x80 on cycle 1 -> wb_adr_o=0x20 until ack; no instr_ack for the 0x20 data; a 0x80 strobe starts the cycle after the ack; instr_ack returns mem[0x80].
- wb_err_i on a 0x40 access (also with ack+err together) -> instr_ack=1, instr_data=ERR_INSTR, instr_err=1.
- TIMEOUT=4, silent slave -> cyc high exactly 5 cycles (launch + 4 BUS); then instr_ack with ERR_INSTR, instr_err=1. TIMEOUT=0 -> cyc stays high indefinitely.
- Cases:
  - Case A: rst asserted during BUS -> cyc=0 in the same cycle; instr_ack=0 after. Address 0x8 fetched, then held through an IF stall -> no second strobe, instr_ack stays 1.
  - Case B: after reset, 0x8 is presented again non-consecutively (0x8, 0xC, 0x8) -> 0x8 strobes only if the buffer now holds 0xC.

Source files
------------

// File: rtl/kronos_imem_bridge.sv
// kronos_imem_bridge
//   Bridges the core's instruction fetch port onto a Wishbone B4 classic
//   read-only master. Every miss becomes one single-beat read cycle. A
//   one-word result buffer answers stalls and repeated addresses without
//   going back to the bus. Bus errors and timeouts fill the buffer with
//   ERR_INSTR and flag instr_err.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     instr_addr/req    fetch address (bits [1:0] ignored) and request
//     instr_data/ack    buffered word; ack means the word belongs to the
//                       address presented in the previous cycle
//     instr_err         qualifies instr_ack: word came from error/timeout
//     wb_*              Wishbone B4 classic master (read only)
module kronos_imem_bridge #(
    parameter logic [31:0] ERR_INSTR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    output logic        instr_err,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [29:0]       addr_q;
    logic              req_q;
    logic              buf_vld_q, buf_vld_d;
    logic [29:0]       buf_addr_q, buf_addr_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              buf_err_q, buf_err_d;
    logic [29:0]       bus_addr_q, bus_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hit;
    logic              launch;
    logic              fill_en;
    logic              fill_err;
    logic [29:0]       fill_addr;

    // Byte-offset bits of the fetch address carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^instr_addr[1:0];

    assign hit    = buf_vld_q && (buf_addr_q == instr_addr[31:2]);
    assign launch = (state_q == IDLE) && instr_req && !hit && !rst;

    // Strobe goes out in the launch cycle itself so a zero-wait slave can
    // answer immediately; reset kills the cycle combinationally.
    assign wb_cyc_o = !rst && (launch || (state_q == BUS));
    assign wb_stb_o = wb_cyc_o;
    assign wb_adr_o = (state_q == BUS) ? {bus_addr_q, 2'b00} : {instr_addr[31:2], 2'b00};
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;

    // Response is built from registers only; rst masks it in the reset cycle.
    assign instr_ack  = !rst && req_q && buf_vld_q && (buf_addr_q == addr_q);
    assign instr_data = buf_data_q;
    assign instr_err  = buf_err_q && instr_ack;

    always_comb begin
        state_d    = state_q;
        bus_addr_d = bus_addr_q;
        cnt_d      = cnt_q;
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_err_d  = buf_err_q;
        fill_en    = 1'b0;
        fill_err   = 1'b0;
        fill_addr  = bus_addr_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    fill_addr = instr_addr[31:2];
                    if (wb_err_i) begin
                        fill_en  = 1'b1;
                        fill_err = 1'b1;
                    end else if (wb_ack_i) begin
                        fill_en = 1'b1;
                    end else begin
                        state_d    = BUS;
                        bus_addr_d = instr_addr[31:2];
                        cnt_d      = '0;
                    end
                end
            end
            BUS: begin
                // Error has priority over ack when both arrive together.
                if (wb_err_i) begin
                    fill_en  = 1'b1;
                    fill_err = 1'b1;
                    state_d  = IDLE;
                end else if (wb_ack_i) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    fill_en  = 1'b1;
                    fill_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (fill_en) begin
            buf_vld_d  = 1'b1;
            buf_addr_d = fill_addr;
            buf_data_d = fill_err ? ERR_INSTR : wb_dat_i;
            buf_err_d  = fill_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_vld_q  <= 1'b0;
            buf_data_q <= '0;
            buf_err_q  <= 1'b0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_vld_q  <= buf_vld_d;
            buf_data_q <= buf_data_d;
            buf_err_q  <= buf_err_d;
            req_q      <= instr_req;
            cnt_q      <= cnt_d;
        end
    end

    // Address registers are only meaningful alongside their valid/state
    // flags, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q     <= instr_addr[31:2];
        buf_addr_q <= buf_addr_d;
        bus_addr_q <= bus_addr_d;
    end

endmodule

// File: tb/tb_kronos_imem_bridge.sv
module tb_kronos_imem_bridge;

    localparam logic [31:0] ERR_W = 32'h0BAD_0001;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        instr_ack, instr_err;
    logic [31:0] wb_adr_o, wb_dat_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
    logic [3:0]  wb_sel_o;

    // second instance with the timeout disabled and a slave that never answers
    logic        d0_cyc, d0_ack;
    logic [31:0] unused_d0_data, unused_d0_adr;
    logic        unused_d0_err, unused_d0_stb, unused_d0_we;
    logic [3:0]  unused_d0_sel;

    kronos_imem_bridge #(.ERR_INSTR(ERR_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_ack(instr_ack), .instr_err(instr_err),
        .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i));

    kronos_imem_bridge #(.ERR_INSTR(ERR_W), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(unused_d0_data), .instr_ack(d0_ack), .instr_err(unused_d0_err),
        .wb_adr_o(unused_d0_adr), .wb_dat_i(32'h0), .wb_cyc_o(d0_cyc), .wb_stb_o(unused_d0_stb),
        .wb_we_o(unused_d0_we), .wb_sel_o(unused_d0_sel), .wb_ack_i(1'b0), .wb_err_i(1'b0));

    // ---------------- memory and slave ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0011;
            32'h4:   return 32'h0000_0022;
            32'h8:   return 32'h0000_0033;
            32'h100: return 32'hDEAD_BEEF;
            32'h80:  return 32'hCAFE_0080;
            default: return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
        endcase
    endfunction

    int slv_lat  = 0;  // cycles after strobe before the response
    int slv_mode = 0;  // 0 ack, 1 err, 2 ack+err, 3 silent
    int scnt     = 0;
    logic s_hit;

    always_comb begin
        s_hit    = wb_cyc_o && wb_stb_o && (scnt == slv_lat) && (slv_mode != 3);
        wb_ack_i = s_hit && (slv_mode != 1);
        wb_err_i = s_hit && (slv_mode != 0);
        wb_dat_i = mem_word(wb_adr_o);
    end

    always @(posedge clk) begin
        if (!wb_cyc_o || wb_ack_i || wb_err_i) scnt <= 0;
        else scnt <= scnt + 1;
    end

    // count bus transfers started
    int   starts    = 0;
    logic prev_stb  = 1'b0;
    logic prev_term = 1'b0;
    always @(posedge clk) begin
        if (wb_stb_o && (!prev_stb || prev_term)) starts <= starts + 1;
        prev_stb  <= wb_stb_o;
        prev_term <= wb_ack_i || wb_err_i;
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one cycle: inputs change just after the edge, checks follow once settled
    task automatic step(input logic r, input logic q, input logic [31:0] a,
                        input int lat, input int mode);
        @(posedge clk);
        #1;
        rst = r; instr_req = q; instr_addr = a; slv_lat = lat; slv_mode = mode;
        #1;
    endtask

    // ---------------- reference model state ----------------
    bit          m_vld, m_err, infl, p_req;
    logic [29:0] m_addr, fl_addr, p_addr;
    logic [31:0] m_data;
    int          fl_done, cur_lat, cur_mode;

    task automatic model_fill(input logic [29:0] w, input int mode);
        m_vld  = 1'b1;
        m_addr = w;
        m_err  = (mode != 0);
        m_data = (mode != 0) ? ERR_W : mem_word({w, 2'b00});
    endtask

    typedef struct {
        int          lat;
        int          mode;
        logic        req;
        logic [31:0] addr;
        logic        e_ack;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_cyc;
        logic [31:0] e_adr;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, ncyc, ack_at;
        logic [31:0] ack_data;
        logic        ack_err;

        rst = 1'b1; instr_req = 1'b0; instr_addr = '0;

        //        lat mode req addr     ack data          err  cyc adr
        tbl[0]  = '{0, 0, 1'b1, 32'h0,   1'b0, 32'h0,        1'b0, 1'b1, 32'h0};
        tbl[1]  = '{0, 0, 1'b1, 32'h4,   1'b1, 32'h11,       1'b0, 1'b1, 32'h4};
        tbl[2]  = '{0, 0, 1'b1, 32'h8,   1'b1, 32'h22,       1'b0, 1'b1, 32'h8};
        tbl[3]  = '{0, 0, 1'b0, 32'h8,   1'b1, 32'h33,       1'b0, 1'b0, 32'h0};
        tbl[4]  = '{0, 0, 1'b0, 32'h8,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1, 0, 1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100};
        tbl[6]  = '{1, 0, 1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100};
        tbl[7]  = '{1, 0, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{0, 1, 1'b1, 32'h40,  1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h40};
        tbl[9]  = '{0, 1, 1'b1, 32'h40,  1'b1, ERR_W,        1'b1, 1'b0, 32'h0};
        tbl[10] = '{0, 2, 1'b1, 32'h44,  1'b1, ERR_W,        1'b1, 1'b1, 32'h44};
        tbl[11] = '{0, 0, 1'b0, 32'h44,  1'b1, ERR_W,        1'b1, 1'b0, 32'h0};
        tbl[12] = '{0, 0, 1'b1, 32'h44,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[13] = '{0, 0, 1'b1, 32'h0,   1'b1, ERR_W,        1'b1, 1'b1, 32'h0};
        tbl[14] = '{0, 0, 1'b1, 32'h0,   1'b1, 32'h11,       1'b0, 1'b0, 32'h0};

        // reset behaviour
        step(1'b1, 1'b0, 32'h0, 0, 0);
        step(1'b1, 1'b1, 32'h40, 0, 0);
        chk1("rst_cyc_gated", wb_cyc_o, 1'b0);
        chk1("rst_ack", instr_ack, 1'b0);
        step(1'b0, 1'b0, 32'h0, 0, 0);
        chk1("reset_ack", instr_ack, 1'b0);
        chk32("reset_data", instr_data, 32'h0);
        chk1("reset_err", instr_err, 1'b0);
        chk1("reset_cyc", wb_cyc_o, 1'b0);
        chk1("we_const", wb_we_o, 1'b0);
        chk32("sel_const", {28'h0, wb_sel_o}, 32'hF);

        // table: zero-wait stream, one-wait slave, error and ack+err
        s0 = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, tbl[i].req, tbl[i].addr, tbl[i].lat, tbl[i].mode);
            if (i == 0) s0 = starts;
            if (i == 5) chk32("zero_wait_strobes", 32'(starts - s0), 32'd3);
            chk1($sformatf("tbl%0d_ack", i), instr_ack, tbl[i].e_ack);
            if (tbl[i].e_ack) chk32($sformatf("tbl%0d_data", i), instr_data, tbl[i].e_data);
            chk1($sformatf("tbl%0d_err", i), instr_err, tbl[i].e_err);
            chk1($sformatf("tbl%0d_cyc", i), wb_cyc_o, tbl[i].e_cyc);
            chk1($sformatf("tbl%0d_stb", i), wb_stb_o, tbl[i].e_cyc);
            if (tbl[i].e_cyc) chk32($sformatf("tbl%0d_adr", i), wb_adr_o, tbl[i].e_adr);
        end

        // branch while an access is in flight (3-cycle slave)
        step(1'b0, 1'b1, 32'h20, 3, 0);
        chk1("br_launch_cyc", wb_cyc_o, 1'b1);
        chk32("br_launch_adr", wb_adr_o, 32'h20);
        chk1("br_prev_ack", instr_ack, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b1, 32'h80, 3, 0);
            chk1($sformatf("br_ack_c%0d", k), instr_ack, 1'b0);
            chk1($sformatf("br_cyc_c%0d", k), wb_cyc_o, 1'b1);
            chk32($sformatf("br_adr_c%0d", k), wb_adr_o, (k <= 3) ? 32'h20 : 32'h80);
        end
        step(1'b0, 1'b1, 32'h80, 3, 0);
        chk1("br_final_ack", instr_ack, 1'b1);
        chk32("br_final_data", instr_data, 32'hCAFE0080);
        chk1("br_final_cyc", wb_cyc_o, 1'b0);

        // timeout with a silent slave; TIMEOUT=0 instance never gives up
        step(1'b1, 1'b0, 32'h0, 0, 3);
        ncyc = 0; ack_at = -1; ack_data = '0; ack_err = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 32'h200, 0, 3);
            if (wb_cyc_o) ncyc++;
            if (instr_ack && ack_at < 0) begin
                ack_at = k; ack_data = instr_data; ack_err = instr_err;
            end
            chk1($sformatf("to0_cyc_k%0d", k), d0_cyc, 1'b1);
            chk1($sformatf("to0_ack_k%0d", k), d0_ack, 1'b0);
        end
        chk32("timeout_cyc_cycles", 32'(ncyc), 32'd5);
        chk32("timeout_ack_cycle", 32'(ack_at), 32'd5);
        chk32("timeout_data", ack_data, ERR_W);
        chk1("timeout_err", ack_err, 1'b1);

        // case A: reset during BUS, then a stalled fetch
        step(1'b1, 1'b0, 32'h0, 3, 0);
        step(1'b0, 1'b1, 32'h300, 3, 0);
        chk1("ra_launch_cyc", wb_cyc_o, 1'b1);
        step(1'b0, 1'b1, 32'h300, 3, 0);
        chk1("ra_bus_cyc", wb_cyc_o, 1'b1);
        step(1'b1, 1'b1, 32'h300, 3, 0);
        chk1("ra_rst_cyc", wb_cyc_o, 1'b0);
        chk1("ra_rst_ack", instr_ack, 1'b0);
        step(1'b0, 1'b1, 32'h300, 3, 0);
        chk1("ra_after_ack", instr_ack, 1'b0);
        chk1("ra_relaunch_cyc", wb_cyc_o, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 32'h300, 3, 0);
            chk1($sformatf("ra_wait_ack%0d", k), instr_ack, 1'b0);
        end
        step(1'b0, 1'b1, 32'h300, 3, 0);
        chk1("ra_ack", instr_ack, 1'b1);
        chk32("ra_data", instr_data, mem_word(32'h300));
        s0 = starts;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 32'h300, 3, 0);
            chk1($sformatf("stall_ack%0d", k), instr_ack, 1'b1);
            chk1($sformatf("stall_cyc%0d", k), wb_cyc_o, 1'b0);
        end
        chk32("stall_no_strobe", 32'(starts - s0), 32'd0);

        // case B: 0x8 revisited non-consecutively
        step(1'b1, 1'b0, 32'h0, 0, 0);
        step(1'b0, 1'b1, 32'h8, 0, 0);
        chk1("rb0_cyc", wb_cyc_o, 1'b1);
        step(1'b0, 1'b1, 32'hC, 0, 0);
        chk1("rb1_cyc", wb_cyc_o, 1'b1);
        chk32("rb1_data", instr_data, 32'h33);
        step(1'b0, 1'b1, 32'h8, 0, 0);
        chk1("rb2_cyc", wb_cyc_o, 1'b1);
        chk32("rb2_adr", wb_adr_o, 32'h8);
        chk1("rb2_ack", instr_ack, 1'b1);
        chk32("rb2_data", instr_data, mem_word(32'hC));
        step(1'b0, 1'b0, 32'hC, 0, 0);
        chk1("rb3_cyc", wb_cyc_o, 1'b0);
        chk1("rb3_ack", instr_ack, 1'b1);
        chk32("rb3_data", instr_data, 32'h33);
        step(1'b0, 1'b1, 32'h8, 0, 0);
        chk1("rb4_cyc", wb_cyc_o, 1'b0);
        chk1("rb4_ack", instr_ack, 1'b0);

        // randomized traffic against a transaction-level model
        step(1'b1, 1'b0, 32'h0, 0, 0);
        m_vld = 0; m_err = 0; m_data = '0; m_addr = '0; infl = 0; p_req = 0; p_addr = '0;
        fl_addr = '0; fl_done = 0; cur_lat = 0; cur_mode = 0;
        for (int t = 0; t < 600; t++) begin
            logic        r, q, e_ack, launch, e_cyc;
            logic [31:0] a, e_adr;
            int          pick;
            r = ($urandom_range(99) < 2);
            q = ($urandom_range(99) < 80);
            a = 32'h1000 + 32'($urandom_range(5)) * 4 + 32'($urandom_range(3));
            if (!infl) begin
                cur_lat = int'($urandom_range(3));
                pick = int'($urandom_range(99));
                cur_mode = (pick < 70) ? 0 : (pick < 85) ? 1 : 2;
            end
            step(r, q, a, cur_lat, cur_mode);

            e_ack  = !r && p_req && m_vld && (m_addr == p_addr);
            launch = !r && !infl && q && !(m_vld && (m_addr == a[31:2]));
            e_cyc  = !r && (infl || launch);
            e_adr  = infl ? {fl_addr, 2'b00} : {a[31:2], 2'b00};
            chk1("rnd_ack", instr_ack, e_ack);
            if (e_ack) chk32("rnd_data", instr_data, m_data);
            chk1("rnd_err", instr_err, e_ack && m_err);
            chk1("rnd_cyc", wb_cyc_o, e_cyc);
            chk1("rnd_stb", wb_stb_o, e_cyc);
            if (e_cyc) chk32("rnd_adr", wb_adr_o, e_adr);

            if (r) begin
                m_vld = 0; m_err = 0; m_data = '0; infl = 0; p_req = 0;
            end else begin
                if (infl) begin
                    if (t == fl_done) begin
                        model_fill(fl_addr, cur_mode);
                        infl = 0;
                    end
                end else if (launch) begin
                    if (cur_lat == 0) model_fill(a[31:2], cur_mode);
                    else begin
                        infl = 1; fl_addr = a[31:2]; fl_done = t + cur_lat;
                    end
                end
                p_req = q;
            end
            p_addr = a[31:2];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
